// File: rtl/inst_fetch_if.sv
// Bundles the fetch unit's two buses: the program-memory read port and the
// valid/ready handshake that hands instruction words to the execute stage.
interface inst_fetch_if #(
    parameter int ADDR_W = 8
);
    logic              imem_rd_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic [31:0]       ir;
    logic              ir_valid;
    logic              ir_ready;

    // Fetch unit side: drives the memory request and the instruction offer.
    modport master (
        output imem_rd_en,
        output imem_addr,
        output ir,
        output ir_valid,
        input  imem_rdata,
        input  ir_ready
    );

    // Environment side: the program memory and the execute stage.
    modport slave (
        input  imem_rd_en,
        input  imem_addr,
        input  ir,
        input  ir_valid,
        output imem_rdata,
        output ir_ready
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: reads one word at a time from a synchronous-read
// program memory, holds it in ir until the execute stage accepts it, counts
// issued instructions and stops when a HALT opcode is fetched.
module inst_fetch_unit #(
    parameter int              ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] START_PC = '0,
    parameter logic [4:0]      HALT_OP  = 5'b11111,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              start,
    inst_fetch_if.master      bus,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [CNT_W-1:0]  issue_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAPT,
        ISSUE,
        HALTED
    } state_t;

    state_t      state;
    logic        rd_en_q;
    logic [31:0] ir_q;
    logic        ir_valid_q;

    // The memory address is always the pc; every other output is a register.
    assign bus.imem_rd_en = rd_en_q;
    assign bus.imem_addr  = pc;
    assign bus.ir         = ir_q;
    assign bus.ir_valid   = ir_valid_q;

    // Fetch sequencer: one outstanding read, issue on handshake, stop on HALT.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            pc         <= START_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            rd_en_q    <= 1'b0;
            halted     <= 1'b0;
            issue_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pc        <= START_PC;
                        issue_cnt <= '0;
                        rd_en_q   <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    rd_en_q <= 1'b0;
                    state   <= CAPT;
                end
                CAPT: begin
                    ir_q <= bus.imem_rdata;
                    if (bus.imem_rdata[31:27] == HALT_OP) begin
                        halted <= 1'b1;
                        state  <= HALTED;
                    end else begin
                        ir_valid_q <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.ir_ready) begin
                        ir_valid_q <= 1'b0;
                        pc         <= pc + 1'b1;
                        if (issue_cnt != {CNT_W{1'b1}}) begin
                            issue_cnt <= issue_cnt + 1'b1;
                        end
                        rd_en_q <= 1'b1;
                        state   <= REQ;
                    end
                end
                HALTED: begin
                    if (start) begin
                        halted    <= 1'b0;
                        pc        <= START_PC;
                        issue_cnt <= '0;
                        rd_en_q   <= 1'b1;
                        state     <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed testbench for inst_fetch_unit. Three instances are used: the
// default configuration, one with START_PC=255 for pc wrap-around, and one
// with a 2-bit issue counter for saturation.
module tb_inst_fetch_unit;

    logic clk = 1'b0;
    logic sys_rst = 1'b1;
    logic start_m = 1'b0;
    logic start_w = 1'b0;
    logic start_s = 1'b0;

    logic [7:0]  pc_m, pc_w, pc_s;
    logic        halted_m, halted_w, halted_s;
    logic [15:0] cnt_m, cnt_w;
    logic [1:0]  cnt_s;

    logic [31:0] mem_m [256];
    logic [31:0] mem_w [256];
    logic [31:0] mem_s [256];

    int tests_run = 0;
    int tests_failed = 0;

    inst_fetch_if #(.ADDR_W(8)) bus_m ();
    inst_fetch_if #(.ADDR_W(8)) bus_w ();
    inst_fetch_if #(.ADDR_W(8)) bus_s ();

    inst_fetch_unit dut_m (
        .clk(clk), .sys_rst(sys_rst), .start(start_m), .bus(bus_m),
        .pc(pc_m), .halted(halted_m), .issue_cnt(cnt_m)
    );

    inst_fetch_unit #(.START_PC(8'd255)) dut_w (
        .clk(clk), .sys_rst(sys_rst), .start(start_w), .bus(bus_w),
        .pc(pc_w), .halted(halted_w), .issue_cnt(cnt_w)
    );

    inst_fetch_unit #(.CNT_W(2)) dut_s (
        .clk(clk), .sys_rst(sys_rst), .start(start_s), .bus(bus_s),
        .pc(pc_s), .halted(halted_s), .issue_cnt(cnt_s)
    );

    always #5 clk = ~clk;

    // Synchronous-read program memories: data appears one edge after rd_en.
    always @(posedge clk) begin
        if (bus_m.imem_rd_en) bus_m.imem_rdata <= mem_m[bus_m.imem_addr];
        if (bus_w.imem_rd_en) bus_w.imem_rdata <= mem_w[bus_w.imem_addr];
        if (bus_s.imem_rd_en) bus_s.imem_rdata <= mem_s[bus_s.imem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        tick();
        tests_run++;
        if (pc_m !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_pc: got %0d expected 0", pc_m); end
        tests_run++;
        if (bus_m.ir !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_ir: got %h expected 00000000", bus_m.ir); end
        tests_run++;
        if ({bus_m.ir_valid, bus_m.imem_rd_en, halted_m} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_flags: got %b expected 000", {bus_m.ir_valid, bus_m.imem_rd_en, halted_m}); end
        tests_run++;
        if (cnt_m !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_cnt: got %0d expected 0", cnt_m); end
        tests_run++;
        if (pc_w !== 8'd255) begin tests_failed++; $display("[TB] FAIL reset_pc_wrapcfg: got %0d expected 255", pc_w); end
        sys_rst = 1'b0;
        tick();
        tests_run++;
        if ({bus_m.ir_valid, bus_m.imem_rd_en} !== 2'b00) begin tests_failed++; $display("[TB] FAIL idle_quiet: got %b expected 00", {bus_m.ir_valid, bus_m.imem_rd_en}); end
    endtask

    task automatic test_basic();
        bus_m.ir_ready = 1'b1;
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        tests_run++;
        if ({bus_m.imem_rd_en, bus_m.ir_valid} !== 2'b10 || bus_m.imem_addr !== 8'd0) begin tests_failed++; $display("[TB] FAIL basic_req: got rd_en/valid %b addr %0d expected 10 addr 0", {bus_m.imem_rd_en, bus_m.ir_valid}, bus_m.imem_addr); end
        tick();
        tests_run++;
        if ({bus_m.imem_rd_en, bus_m.ir_valid} !== 2'b00) begin tests_failed++; $display("[TB] FAIL basic_capt: got %b expected 00", {bus_m.imem_rd_en, bus_m.ir_valid}); end
        tick();
        tests_run++;
        if (bus_m.ir_valid !== 1'b1 || bus_m.ir !== 32'h08400005 || pc_m !== 8'd0) begin tests_failed++; $display("[TB] FAIL basic_first: got valid %b ir %h pc %0d expected 1 08400005 0", bus_m.ir_valid, bus_m.ir, pc_m); end
        tick();
        tests_run++;
        if (pc_m !== 8'd1 || bus_m.ir_valid !== 1'b0 || cnt_m !== 16'd1) begin tests_failed++; $display("[TB] FAIL basic_hs1: got pc %0d valid %b cnt %0d expected 1 0 1", pc_m, bus_m.ir_valid, cnt_m); end
        tick();
        tick();
        tests_run++;
        if (bus_m.ir_valid !== 1'b1 || bus_m.ir !== 32'h10820003 || pc_m !== 8'd1) begin tests_failed++; $display("[TB] FAIL basic_second: got valid %b ir %h pc %0d expected 1 10820003 1", bus_m.ir_valid, bus_m.ir, pc_m); end
        tick();
        tick();
        tests_run++;
        if (bus_m.ir_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_capt_halt: got valid %b expected 0", bus_m.ir_valid); end
        tick();
        tests_run++;
        if (halted_m !== 1'b1 || pc_m !== 8'd2 || cnt_m !== 16'd2) begin tests_failed++; $display("[TB] FAIL basic_halted: got halted %b pc %0d cnt %0d expected 1 2 2", halted_m, pc_m, cnt_m); end
        tests_run++;
        if (bus_m.ir !== 32'hF8000000) begin tests_failed++; $display("[TB] FAIL basic_halt_ir: got %h expected f8000000", bus_m.ir); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if ({bus_m.ir_valid, bus_m.imem_rd_en, halted_m} !== 3'b001 || pc_m !== 8'd2) begin tests_failed++; $display("[TB] FAIL basic_halt_hold: got valid/rd/halted %b pc %0d expected 001 2", {bus_m.ir_valid, bus_m.imem_rd_en, halted_m}, pc_m); end
        end
    endtask

    task automatic test_restart();
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        bus_m.ir_ready = 1'b0;
        tests_run++;
        if (halted_m !== 1'b0 || cnt_m !== 16'd0 || pc_m !== 8'd0) begin tests_failed++; $display("[TB] FAIL restart_clear: got halted %b cnt %0d pc %0d expected 0 0 0", halted_m, cnt_m, pc_m); end
        tests_run++;
        if (bus_m.imem_rd_en !== 1'b1 || bus_m.imem_addr !== 8'd0) begin tests_failed++; $display("[TB] FAIL restart_req: got rd_en %b addr %0d expected 1 0", bus_m.imem_rd_en, bus_m.imem_addr); end
        tick();
        tick();
        tests_run++;
        if (bus_m.ir_valid !== 1'b1 || bus_m.ir !== 32'h08400005) begin tests_failed++; $display("[TB] FAIL restart_refetch: got valid %b ir %h expected 1 08400005", bus_m.ir_valid, bus_m.ir); end
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        tests_run++;
        if (bus_m.ir_valid !== 1'b1 || bus_m.imem_rd_en !== 1'b0 || pc_m !== 8'd0 || cnt_m !== 16'd0) begin tests_failed++; $display("[TB] FAIL restart_start_in_issue: got valid %b rd %b pc %0d cnt %0d expected 1 0 0 0", bus_m.ir_valid, bus_m.imem_rd_en, pc_m, cnt_m); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) begin
            tick();
            tests_run++;
            if (bus_m.ir !== 32'h08400005 || bus_m.ir_valid !== 1'b1 || pc_m !== 8'd0 || bus_m.imem_rd_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_hold cycle %0d: got ir %h valid %b pc %0d rd %b expected 08400005 1 0 0", i, bus_m.ir, bus_m.ir_valid, pc_m, bus_m.imem_rd_en); end
        end
        bus_m.ir_ready = 1'b1;
        tick();
        bus_m.ir_ready = 1'b0;
        tests_run++;
        if (pc_m !== 8'd1 || bus_m.ir_valid !== 1'b0 || cnt_m !== 16'd1) begin tests_failed++; $display("[TB] FAIL stall_release: got pc %0d valid %b cnt %0d expected 1 0 1", pc_m, bus_m.ir_valid, cnt_m); end
        tests_run++;
        if (bus_m.imem_rd_en !== 1'b1 || bus_m.imem_addr !== 8'd1) begin tests_failed++; $display("[TB] FAIL stall_next_req: got rd %b addr %0d expected 1 1", bus_m.imem_rd_en, bus_m.imem_addr); end
        tick();
        tick();
        tick();
        tick();
        tests_run++;
        if (bus_m.ir !== 32'h10820003 || bus_m.ir_valid !== 1'b1 || pc_m !== 8'd1 || cnt_m !== 16'd1) begin tests_failed++; $display("[TB] FAIL stall_single_hs: got ir %h valid %b pc %0d cnt %0d expected 10820003 1 1 1", bus_m.ir, bus_m.ir_valid, pc_m, cnt_m); end
    endtask

    task automatic test_reset_mid();
        bus_m.ir_ready = 1'b1;
        tick();
        bus_m.ir_ready = 1'b0;
        tick();
        tests_run++;
        if (pc_m !== 8'd2 || cnt_m !== 16'd2 || bus_m.imem_rd_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_setup: got pc %0d cnt %0d rd %b expected 2 2 0", pc_m, cnt_m, bus_m.imem_rd_en); end
        #1;
        sys_rst = 1'b1;
        #1;
        tests_run++;
        if (pc_m !== 8'd0 || cnt_m !== 16'd0 || bus_m.ir_valid !== 1'b0 || halted_m !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_async: got pc %0d cnt %0d valid %b halted %b expected 0 0 0 0", pc_m, cnt_m, bus_m.ir_valid, halted_m); end
        tests_run++;
        if (bus_m.ir !== 32'h0) begin tests_failed++; $display("[TB] FAIL midrst_ir: got %h expected 00000000", bus_m.ir); end
        tick();
        sys_rst = 1'b0;
        tick();
        tick();
        tests_run++;
        if (bus_m.ir !== 32'h0 || bus_m.ir_valid !== 1'b0 || bus_m.imem_rd_en !== 1'b0 || halted_m !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_after: got ir %h valid %b rd %b halted %b expected 00000000 0 0 0", bus_m.ir, bus_m.ir_valid, bus_m.imem_rd_en, halted_m); end
    endtask

    task automatic test_wrap();
        bus_w.ir_ready = 1'b1;
        start_w = 1'b1;
        tick();
        start_w = 1'b0;
        tests_run++;
        if (bus_w.imem_addr !== 8'd255 || bus_w.imem_rd_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_req: got addr %0d rd %b expected 255 1", bus_w.imem_addr, bus_w.imem_rd_en); end
        tick();
        tick();
        tests_run++;
        if (bus_w.ir !== 32'h08400005 || pc_w !== 8'd255 || bus_w.ir_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_issue: got ir %h pc %0d valid %b expected 08400005 255 1", bus_w.ir, pc_w, bus_w.ir_valid); end
        tick();
        tests_run++;
        if (pc_w !== 8'd0 || bus_w.imem_addr !== 8'd0 || bus_w.imem_rd_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_pc: got pc %0d addr %0d rd %b expected 0 0 1", pc_w, bus_w.imem_addr, bus_w.imem_rd_en); end
        tick();
        tick();
        tests_run++;
        if (bus_w.ir !== 32'h10820003 || pc_w !== 8'd0) begin tests_failed++; $display("[TB] FAIL wrap_fetch0: got ir %h pc %0d expected 10820003 0", bus_w.ir, pc_w); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        bus_s.ir_ready = 1'b1;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            tick();
            tests_run++;
            if (cnt_s !== exp_cnt[i]) begin tests_failed++; $display("[TB] FAIL sat_cnt issue %0d: got %0d expected %0d", i, cnt_s, exp_cnt[i]); end
            tick();
        end
        tick();
        tick();
        tests_run++;
        if (halted_s !== 1'b1 || pc_s !== 8'd5 || cnt_s !== 2'd3) begin tests_failed++; $display("[TB] FAIL sat_halt: got halted %b pc %0d cnt %0d expected 1 5 3", halted_s, pc_s, cnt_s); end
    endtask

    // Loads the three program images, then runs each scenario in turn.
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_m[i] = 32'h0;
            mem_w[i] = 32'hF8000000;
            mem_s[i] = 32'hF8000000;
        end
        mem_m[0] = 32'h08400005;
        mem_m[1] = 32'h10820003;
        mem_m[2] = 32'hF8000000;
        mem_w[255] = 32'h08400005;
        mem_w[0]   = 32'h10820003;
        for (int i = 0; i < 5; i++) mem_s[i] = 32'h08400000 + i;
        bus_m.ir_ready = 1'b0;
        bus_w.ir_ready = 1'b0;
        bus_s.ir_ready = 1'b0;

        test_reset();
        test_basic();
        test_restart();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        test_saturation();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
